// File: rtl/uart_rx_frame_ctrl.sv
// Frame sequencer between uart_rx and a 32-bit valid/ready datapath: parses
// length-prefixed frames, packs payload little-endian, aborts on inter-byte timeout.
module uart_rx_frame_ctrl #(
  parameter int TIMEOUT_CLKS = 1048575
) (
  input  logic        i_Clock,
  input  logic        reset,
  input  logic        i_enable,
  input  logic        i_Rx_DV,
  input  logic [7:0]  i_Rx_Byte,
  output logic        o_receive,
  output logic [31:0] o_word,
  output logic        o_word_valid,
  input  logic        i_word_ready,
  output logic [2:0]  o_word_bytes,
  output logic        o_word_last,
  output logic        o_frame_done,
  output logic        o_frame_err,
  output logic        o_busy
);

  typedef enum logic [1:0] {
    S_WAIT_LEN = 2'd0,
    S_PAYLOAD  = 2'd1,
    S_HOLD     = 2'd2
  } state_t;

  localparam logic [19:0] TIMEOUT_LAST_C = 20'(TIMEOUT_CLKS - 1);

  state_t      state_r,      state_nxt_s;
  logic [7:0]  remaining_r,  remaining_nxt_s;
  logic [1:0]  byte_idx_r,   byte_idx_nxt_s;
  logic [19:0] timer_r,      timer_nxt_s;
  logic [31:0] word_r,       word_nxt_s;
  logic        word_valid_r, word_valid_nxt_s;
  logic [2:0]  word_bytes_r, word_bytes_nxt_s;
  logic        word_last_r,  word_last_nxt_s;
  logic        frame_done_r, frame_done_nxt_s;
  logic        frame_err_r,  frame_err_nxt_s;

  // State and datapath register bank
  always_ff @(posedge i_Clock) begin
    if (reset) begin
      state_r      <= S_WAIT_LEN;
      remaining_r  <= 8'd0;
      byte_idx_r   <= 2'd0;
      timer_r      <= 20'd0;
      word_r       <= 32'd0;
      word_valid_r <= 1'b0;
      word_bytes_r <= 3'd0;
      word_last_r  <= 1'b0;
      frame_done_r <= 1'b0;
      frame_err_r  <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      remaining_r  <= remaining_nxt_s;
      byte_idx_r   <= byte_idx_nxt_s;
      timer_r      <= timer_nxt_s;
      word_r       <= word_nxt_s;
      word_valid_r <= word_valid_nxt_s;
      word_bytes_r <= word_bytes_nxt_s;
      word_last_r  <= word_last_nxt_s;
      frame_done_r <= frame_done_nxt_s;
      frame_err_r  <= frame_err_nxt_s;
    end
  end

  // Next-state and next-register decode
  always_comb begin
    state_nxt_s      = state_r;
    remaining_nxt_s  = remaining_r;
    byte_idx_nxt_s   = byte_idx_r;
    timer_nxt_s      = timer_r;
    word_nxt_s       = word_r;
    word_valid_nxt_s = word_valid_r;
    word_bytes_nxt_s = word_bytes_r;
    word_last_nxt_s  = word_last_r;
    frame_done_nxt_s = 1'b0;
    frame_err_nxt_s  = 1'b0;

    case (state_r)
      S_WAIT_LEN: begin
        if (i_Rx_DV) begin
          if (i_Rx_Byte == 8'd0) begin
            frame_done_nxt_s = 1'b1;
          end else begin
            remaining_nxt_s = i_Rx_Byte;
            byte_idx_nxt_s  = 2'd0;
            word_nxt_s      = 32'd0;
            timer_nxt_s     = 20'd0;
            state_nxt_s     = S_PAYLOAD;
          end
        end else begin
          timer_nxt_s = timer_r;
        end
      end

      S_PAYLOAD: begin
        // A byte on the expiry cycle wins over the timeout
        if (i_Rx_DV) begin
          case (byte_idx_r)
            2'd0:    word_nxt_s[7:0]   = i_Rx_Byte;
            2'd1:    word_nxt_s[15:8]  = i_Rx_Byte;
            2'd2:    word_nxt_s[23:16] = i_Rx_Byte;
            2'd3:    word_nxt_s[31:24] = i_Rx_Byte;
            default: word_nxt_s        = word_r;
          endcase
          remaining_nxt_s = remaining_r - 8'd1;
          timer_nxt_s     = 20'd0;
          if ((byte_idx_r == 2'd3) || (remaining_r == 8'd1)) begin
            state_nxt_s      = S_HOLD;
            word_valid_nxt_s = 1'b1;
            word_bytes_nxt_s = {1'b0, byte_idx_r} + 3'd1;
            word_last_nxt_s  = (remaining_r == 8'd1);
          end else begin
            byte_idx_nxt_s = byte_idx_r + 2'd1;
          end
        end else if (timer_r == TIMEOUT_LAST_C) begin
          frame_err_nxt_s = 1'b1;
          word_nxt_s      = 32'd0;
          byte_idx_nxt_s  = 2'd0;
          timer_nxt_s     = 20'd0;
          state_nxt_s     = S_WAIT_LEN;
        end else begin
          timer_nxt_s = timer_r + 20'd1;
        end
      end

      S_HOLD: begin
        if (i_word_ready) begin
          word_valid_nxt_s = 1'b0;
          word_bytes_nxt_s = 3'd0;
          word_last_nxt_s  = 1'b0;
          word_nxt_s       = 32'd0;
          byte_idx_nxt_s   = 2'd0;
          timer_nxt_s      = 20'd0;
          if (word_last_r) begin
            frame_done_nxt_s = 1'b1;
            state_nxt_s      = S_WAIT_LEN;
          end else begin
            state_nxt_s = S_PAYLOAD;
          end
        end else begin
          state_nxt_s = S_HOLD;
        end
      end

      default: begin
        state_nxt_s = S_WAIT_LEN;
      end
    endcase
  end

  // Receiver gate decoded from registered state so it drops on the first HOLD cycle
  always_comb begin
    o_receive = 1'b0;
    case (state_r)
      S_WAIT_LEN: o_receive = i_enable;
      S_PAYLOAD:  o_receive = 1'b1;
      S_HOLD:     o_receive = 1'b0;
      default:    o_receive = 1'b0;
    endcase
  end

  assign o_word       = word_r;
  assign o_word_valid = word_valid_r;
  assign o_word_bytes = word_bytes_r;
  assign o_word_last  = word_last_r;
  assign o_frame_done = frame_done_r;
  assign o_frame_err  = frame_err_r;
  assign o_busy       = (state_r != S_WAIT_LEN);

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Directed self-checking bench for uart_rx_frame_ctrl (TIMEOUT_CLKS = 100).
module tb_uart_rx_frame_ctrl;

  logic        i_Clock = 1'b0;
  logic        reset;
  logic        i_enable;
  logic        i_Rx_DV;
  logic [7:0]  i_Rx_Byte;
  logic        o_receive;
  logic [31:0] o_word;
  logic        o_word_valid;
  logic        i_word_ready;
  logic [2:0]  o_word_bytes;
  logic        o_word_last;
  logic        o_frame_done;
  logic        o_frame_err;
  logic        o_busy;

  int checks = 0;
  int errors = 0;
  int bad;

  uart_rx_frame_ctrl #(.TIMEOUT_CLKS(100)) dut (
    .i_Clock      (i_Clock),
    .reset        (reset),
    .i_enable     (i_enable),
    .i_Rx_DV      (i_Rx_DV),
    .i_Rx_Byte    (i_Rx_Byte),
    .o_receive    (o_receive),
    .o_word       (o_word),
    .o_word_valid (o_word_valid),
    .i_word_ready (i_word_ready),
    .o_word_bytes (o_word_bytes),
    .o_word_last  (o_word_last),
    .o_frame_done (o_frame_done),
    .o_frame_err  (o_frame_err),
    .o_busy       (o_busy)
  );

  always #5 i_Clock = ~i_Clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One-cycle DV pulse; returns at the negedge after the sampling posedge
  task automatic send_byte(input logic [7:0] b);
    @(negedge i_Clock);
    i_Rx_DV   = 1'b1;
    i_Rx_Byte = b;
    @(negedge i_Clock);
    i_Rx_DV   = 1'b0;
    i_Rx_Byte = 8'h00;
  endtask

  initial begin
    reset = 1'b1; i_enable = 1'b0; i_Rx_DV = 1'b0; i_Rx_Byte = 8'h00; i_word_ready = 1'b0;
    repeat (3) @(negedge i_Clock);
    chk("rst_word", o_word, 32'h0);
    chk("rst_valid", {31'd0, o_word_valid}, 32'd0);
    chk("rst_bytes", {29'd0, o_word_bytes}, 32'd0);
    chk("rst_last", {31'd0, o_word_last}, 32'd0);
    chk("rst_done", {31'd0, o_frame_done}, 32'd0);
    chk("rst_err", {31'd0, o_frame_err}, 32'd0);
    chk("rst_busy", {31'd0, o_busy}, 32'd0);
    chk("rst_recv_en0", {31'd0, o_receive}, 32'd0);
    reset = 1'b0;

    // Zero length and enable
    @(negedge i_Clock);
    chk("en0_recv", {31'd0, o_receive}, 32'd0);
    i_enable = 1'b1;
    #1;
    chk("en1_recv", {31'd0, o_receive}, 32'd1);
    send_byte(8'h00);
    chk("zl_done", {31'd0, o_frame_done}, 32'd1);
    chk("zl_busy", {31'd0, o_busy}, 32'd0);
    @(negedge i_Clock);
    chk("zl_done_pulse", {31'd0, o_frame_done}, 32'd0);

    // Single word with ready held high
    i_word_ready = 1'b1;
    send_byte(8'h04);
    chk("sw_busy", {31'd0, o_busy}, 32'd1);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    chk("sw_valid", {31'd0, o_word_valid}, 32'd1);
    chk("sw_word", o_word, 32'h44332211);
    chk("sw_bytes", {29'd0, o_word_bytes}, 32'd4);
    chk("sw_last", {31'd0, o_word_last}, 32'd1);
    chk("sw_recv_hold", {31'd0, o_receive}, 32'd0);
    @(negedge i_Clock);
    chk("sw_valid_clr", {31'd0, o_word_valid}, 32'd0);
    chk("sw_done", {31'd0, o_frame_done}, 32'd1);
    chk("sw_busy_end", {31'd0, o_busy}, 32'd0);
    @(negedge i_Clock);
    chk("sw_done_pulse", {31'd0, o_frame_done}, 32'd0);
    i_word_ready = 1'b0;

    // Partial last word
    send_byte(8'h06);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    chk("pw1_valid", {31'd0, o_word_valid}, 32'd1);
    chk("pw1_word", o_word, 32'h04030201);
    chk("pw1_bytes", {29'd0, o_word_bytes}, 32'd4);
    chk("pw1_last", {31'd0, o_word_last}, 32'd0);
    chk("pw1_recv", {31'd0, o_receive}, 32'd0);
    i_word_ready = 1'b1;
    @(negedge i_Clock);
    i_word_ready = 1'b0;
    chk("pw1_xfer_valid", {31'd0, o_word_valid}, 32'd0);
    chk("pw1_xfer_recv", {31'd0, o_receive}, 32'd1);
    chk("pw1_no_done", {31'd0, o_frame_done}, 32'd0);
    send_byte(8'h05); send_byte(8'h06);
    chk("pw2_valid", {31'd0, o_word_valid}, 32'd1);
    chk("pw2_word", o_word, 32'h00000605);
    chk("pw2_bytes", {29'd0, o_word_bytes}, 32'd2);
    chk("pw2_last", {31'd0, o_word_last}, 32'd1);
    chk("pw2_recv", {31'd0, o_receive}, 32'd0);
    i_word_ready = 1'b1;
    @(negedge i_Clock);
    i_word_ready = 1'b0;
    chk("pw2_done", {31'd0, o_frame_done}, 32'd1);

    // Back-pressure for 50 cycles, longer than nothing but checks hold stability
    send_byte(8'h04);
    send_byte(8'hA1); send_byte(8'hB2); send_byte(8'hC3); send_byte(8'hD4);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge i_Clock);
      if (o_word !== 32'hD4C3B2A1 || o_receive !== 1'b0 || o_frame_err !== 1'b0 ||
          o_word_valid !== 1'b1 || o_word_bytes !== 3'd4 || o_word_last !== 1'b1) bad++;
    end
    chk("bp_stable", bad, 32'd0);
    i_word_ready = 1'b1;
    @(negedge i_Clock);
    i_word_ready = 1'b0;
    chk("bp_xfer_valid", {31'd0, o_word_valid}, 32'd0);
    chk("bp_done", {31'd0, o_frame_done}, 32'd1);
    chk("bp_recv_back", {31'd0, o_receive}, 32'd1);

    // Timeout: err exactly 100 cycles after the last byte
    send_byte(8'h03);
    send_byte(8'h55);
    bad = 0;
    for (int i = 1; i < 100; i++) begin
      @(negedge i_Clock);
      if (o_frame_err !== 1'b0 || o_word_valid !== 1'b0) bad++;
    end
    chk("to_early_err", bad, 32'd0);
    @(negedge i_Clock);
    chk("to_err", {31'd0, o_frame_err}, 32'd1);
    chk("to_busy", {31'd0, o_busy}, 32'd0);
    chk("to_valid", {31'd0, o_word_valid}, 32'd0);
    @(negedge i_Clock);
    chk("to_err_pulse", {31'd0, o_frame_err}, 32'd0);
    i_word_ready = 1'b1;
    send_byte(8'h02);
    chk("to_len_busy", {31'd0, o_busy}, 32'd1);
    send_byte(8'h0A); send_byte(8'h0B);
    chk("to_next_valid", {31'd0, o_word_valid}, 32'd1);
    chk("to_next_word", o_word, 32'h00000B0A);
    chk("to_next_bytes", {29'd0, o_word_bytes}, 32'd2);
    @(negedge i_Clock);
    chk("to_next_done", {31'd0, o_frame_done}, 32'd1);
    i_word_ready = 1'b0;

    // Reset mid-frame
    send_byte(8'h08);
    send_byte(8'h10); send_byte(8'h20);
    chk("rm_busy", {31'd0, o_busy}, 32'd1);
    reset = 1'b1;
    @(negedge i_Clock);
    reset = 1'b0;
    chk("rm_word", o_word, 32'h0);
    chk("rm_valid", {31'd0, o_word_valid}, 32'd0);
    chk("rm_busy_clr", {31'd0, o_busy}, 32'd0);
    chk("rm_recv", {31'd0, o_receive}, 32'd1);
    bad = 0;
    for (int i = 0; i < 120; i++) begin
      @(negedge i_Clock);
      if (o_frame_err !== 1'b0) bad++;
    end
    chk("rm_no_err", bad, 32'd0);
    send_byte(8'h01);
    send_byte(8'hAB);
    chk("rm_next_valid", {31'd0, o_word_valid}, 32'd1);
    chk("rm_next_word", o_word, 32'h000000AB);
    chk("rm_next_bytes", {29'd0, o_word_bytes}, 32'd1);
    chk("rm_next_last", {31'd0, o_word_last}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_frame_ctrl.md
# uart_rx_frame_ctrl

Sequencer that sits between the `uart_rx` byte receiver and the accelerator's 32-bit input datapath. Drives the receiver's `receive` gate, parses length-prefixed frames from the received byte stream, and packs payload bytes little-endian into 32-bit words presented on a valid/ready interface. Frames are aborted with an error pulse on inter-byte timeout.

## Interface

**Parameters**
- `TIMEOUT_CLKS`, default 1048575: maximum idle clocks between bytes inside a frame before abort. The counter is 20 bits; `TIMEOUT_CLKS` must be ≤ 2^20−1.

**Ports**
- `i_Clock`  in  1  single clock; all logic on posedge.
- `reset`  in  1  synchronous, active-high reset.
- `i_enable`  in  1  permits start of a new frame.
- `i_Rx_DV`  in  1  one-cycle byte-valid pulse from `uart_rx`.
- `i_Rx_Byte`  in  8  received byte, valid while `i_Rx_DV`=1.
- `o_receive`  out  1  to `uart_rx` `receive`.
- `o_word`  out  32  packed payload word; byte k in bits [8k+7:8k].
- `o_word_valid`  out  1  `o_word` holds a word.
- `i_word_ready`  in  1  downstream accepts the word.
- `o_word_bytes`  out  3  valid bytes in `o_word`, 1–4; meaningful only while `o_word_valid`=1.
- `o_word_last`  out  1  `o_word` is the final word of the frame.
- `o_frame_done`  out  1  one-cycle pulse when a frame completes.
- `o_frame_err`  out  1  one-cycle pulse on timeout abort.
- `o_busy`  out  1  high in any state other than S_WAIT_LEN.

## Operation

**Frame format:** length byte L (0–255), followed by L payload bytes.

**Internal registers:** `remaining` (8b), `byte_idx` (2b), `timer` (20b), word buffer (32b).

**States** (3):
- **S_WAIT_LEN**
  - `o_receive = i_enable`, combinational.
  - On `i_Rx_DV`:
    - If L = 0: pulse `o_frame_done`, stay in S_WAIT_LEN.
    - Otherwise: `remaining` ← L, `byte_idx` ← 0, word buffer ← 0, `timer` ← 0, go to S_PAYLOAD.
  - Timer is idle in this state.
- **S_PAYLOAD**
  - `o_receive` = 1. `i_enable` is ignored.
  - On `i_Rx_DV`:
    - Write the byte into lane `byte_idx`; `remaining` ← `remaining`−1; `timer` ← 0.
    - If `byte_idx` = 3 or `remaining` = 1: go to S_HOLD, set `o_word_valid`, `o_word_bytes` ← `byte_idx`+1, `o_word_last` ← (`remaining` = 1).
    - Otherwise: `byte_idx`+1.
  - With no `i_Rx_DV`: `timer`+1.
    - When `timer` = `TIMEOUT_CLKS`−1: pulse `o_frame_err`, discard the partial word, go to S_WAIT_LEN.
  - Unused lanes of a partial word read 0.
- **S_HOLD**
  - `o_receive` = 0; `o_word_valid` = 1; `o_word`, `o_word_bytes`, `o_word_last` held stable.
  - On `i_word_ready`: clear `o_word_valid`.
    - If `o_word_last`: pulse `o_frame_done`, go to S_WAIT_LEN.
    - Otherwise: `byte_idx` ← 0, word buffer ← 0, `timer` ← 0, go to S_PAYLOAD.
  - `i_Rx_DV` cannot occur here, because `receive` is low when `uart_rx` returns to idle. If it does occur, it is ignored.
  - The timer does not run in S_HOLD.
  - Upstream pacing during back-pressure is a system-level responsibility. Bytes sent while `o_receive`=0 are lost.

**Simultaneous events:**
- `reset` overrides everything.
- The timeout compare is evaluated only in cycles without `i_Rx_DV`; a byte arriving on the expiry cycle is accepted.

**Reset mid-frame:** the partial word is discarded with no `o_frame_err`. State → S_WAIT_LEN.

## Timing

- **Reset values:** `o_word`=0, `o_word_valid`=0, `o_word_bytes`=0, `o_word_last`=0, `o_frame_done`=0, `o_frame_err`=0, `o_busy`=0; `o_receive` = `i_enable`.
- **Word latency:** `o_word_valid` rises on the clock edge that samples the completing `i_Rx_DV`, i.e. 1 cycle after the DV pulse.
- **Gating:** `o_receive` is a registered-state decode. It is low from the first cycle of S_HOLD, so `uart_rx` (CLEANUP → IDLE on that same edge) sees `receive`=0.
- **Handshake:** transfer occurs on an edge where `o_word_valid` and `i_word_ready` are both 1.
  - `i_word_ready` may be high early; a word is never presented and accepted in the same cycle it was formed.
- **Frame done:** `o_frame_done` asserts the cycle after the final transfer, or the cycle after an L=0 length byte.
- **Timeout:** `o_frame_err` asserts exactly `TIMEOUT_CLKS` cycles after the last DV, or after the length byte.
- **Throughput:** at most 1 word per 4 byte times, plus 1 handshake cycle.

## Test plan

- **Single word:** L=4, bytes 0x11,0x22,0x33,0x44; ready held high → one word 0x44332211, bytes=4, last=1; `o_frame_done` pulses 1 cycle after transfer.
- **Partial last word:** L=6, bytes 0x01–0x06 → word 0x04030201 (last=0), then 0x00000605 (bytes=2, last=1); `o_receive` low throughout each S_HOLD.
- **Back-pressure:** `i_word_ready` low for 50 cycles after a word forms → `o_word` stable, `o_receive`=0, no timeout; ready high → transfer, `o_receive` returns to 1 the next cycle.
- **Timeout:** `TIMEOUT_CLKS`=100, L=3, send 1 byte then idle → `o_frame_err` pulses 100 cycles after that byte, no word emitted; the next byte is parsed as a length.
- **Zero length and enable:** `i_enable`=0 → `o_receive`=0; enable, send L=0 → `o_frame_done` pulse, `o_busy` stays 0.
- **Reset mid-frame:** reset mid-frame (L=8 after 2 bytes) → all outputs at reset values, no `o_frame_err`; a subsequent L=1 frame with byte 0xAB → word 0x000000AB, bytes=1, last=1.
